// File: rtl/iigs_ram_arbiter.sv
// Shares the IIgs main-RAM port between the CPU bus and the video scanner, one access at a time.
// Optional CPU starvation guard: define IIGS_ARB_STARVE_GUARD_EN.
module iigs_ram_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int RAM_LAT    = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_rdata,
  output logic              vid_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam int CNT_W = $clog2(RAM_LAT + 1);

  if (RAM_LAT < 1 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
    $error("iigs_ram_arbiter: RAM_LAT must be >= 1 and STARVE_MAX within 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    wait_cnt_reg;
  logic                sel_cpu_reg;
  logic                sel_we_reg;

  logic                cpu_pend_reg;
  logic                cpu_we_reg;
  logic [ADDR_W-1:0]   cpu_addr_reg;
  logic [7:0]          cpu_wdata_reg;
  logic                vid_pend_reg;
  logic [ADDR_W-1:0]   vid_addr_reg;

  logic                arb_phase;
  logic                cpu_avail;
  logic                vid_avail;
  logic                cpu_first;
  logic                grant_cpu;
  logic                grant_vid;
  logic                cpu_we_sel;
  logic [ADDR_W-1:0]   cpu_addr_sel;
  logic [7:0]          cpu_wdata_sel;
  logic [ADDR_W-1:0]   vid_addr_sel;

  // A strobe in the arbitration cycle competes directly, bypassing its empty slot.
  assign arb_phase     = (state_reg == S_IDLE) || (state_reg == S_ACK);
  assign cpu_avail     = cpu_pend_reg | cpu_req;
  assign vid_avail     = vid_pend_reg | vid_req;
  assign cpu_we_sel    = cpu_pend_reg ? cpu_we_reg    : cpu_we;
  assign cpu_addr_sel  = cpu_pend_reg ? cpu_addr_reg  : cpu_addr;
  assign cpu_wdata_sel = cpu_pend_reg ? cpu_wdata_reg : cpu_wdata;
  assign vid_addr_sel  = vid_pend_reg ? vid_addr_reg  : vid_addr;

`ifdef IIGS_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_reg;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      starve_cnt_reg <= 4'd0;
    end else if (grant_cpu) begin
      starve_cnt_reg <= 4'd0;
    end else if (cpu_avail && starve_cnt_reg != 4'hF) begin
      starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end
  end

  assign cpu_first = cpu_avail && (starve_cnt_reg >= 4'(STARVE_MAX));
`else
  assign cpu_first = 1'b0;
`endif

  assign grant_vid = arb_phase & vid_avail & ~cpu_first;
  assign grant_cpu = arb_phase & cpu_avail & ~grant_vid;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      wait_cnt_reg  <= '0;
      sel_cpu_reg   <= 1'b0;
      sel_we_reg    <= 1'b0;
      cpu_pend_reg  <= 1'b0;
      cpu_we_reg    <= 1'b0;
      cpu_addr_reg  <= '0;
      cpu_wdata_reg <= 8'd0;
      vid_pend_reg  <= 1'b0;
      vid_addr_reg  <= '0;
      cpu_rdata     <= 8'd0;
      cpu_ack       <= 1'b0;
      vid_rdata     <= 8'd0;
      vid_ack       <= 1'b0;
      ram_en        <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= 8'd0;
    end else begin
      ram_en  <= 1'b0;
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;

      // Slots clear at grant; a strobe into an occupied slot is dropped.
      if (grant_cpu) begin
        cpu_pend_reg <= 1'b0;
      end else if (cpu_req && !cpu_pend_reg) begin
        cpu_pend_reg  <= 1'b1;
        cpu_we_reg    <= cpu_we;
        cpu_addr_reg  <= cpu_addr;
        cpu_wdata_reg <= cpu_wdata;
      end

      if (grant_vid) begin
        vid_pend_reg <= 1'b0;
      end else if (vid_req && !vid_pend_reg) begin
        vid_pend_reg <= 1'b1;
        vid_addr_reg <= vid_addr;
      end

      case (state_reg)
        S_IDLE, S_ACK: begin
          if (grant_vid || grant_cpu) begin
            state_reg   <= S_ISSUE;
            ram_en      <= 1'b1;
            sel_cpu_reg <= grant_cpu;
            if (grant_cpu) begin
              ram_addr   <= cpu_addr_sel;
              ram_we     <= cpu_we_sel;
              ram_wdata  <= cpu_wdata_sel;
              sel_we_reg <= cpu_we_sel;
            end else begin
              ram_addr   <= vid_addr_sel;
              ram_we     <= 1'b0;
              sel_we_reg <= 1'b0;
            end
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_ISSUE: begin
          state_reg    <= S_WAIT;
          wait_cnt_reg <= CNT_W'(RAM_LAT - 1);
        end
        S_WAIT: begin
          if (wait_cnt_reg == '0) begin
            state_reg <= S_ACK;
            if (sel_cpu_reg) begin
              cpu_ack <= 1'b1;
              if (!sel_we_reg) begin
                cpu_rdata <= ram_rdata;
              end
            end else begin
              vid_ack   <= 1'b1;
              vid_rdata <= ram_rdata;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iigs_ram_arbiter.sv
// Directed bench for iigs_ram_arbiter: cycle-by-cycle vector table plus stream and reset sequences.
module tb_iigs_ram_arbiter;

  localparam int ADDR_W  = 24;
  localparam int RAM_LAT = 2;
  localparam int NV      = 36;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_rdata;
  logic              vid_ack;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  always #5 clk_sys = ~clk_sys;

  iigs_ram_arbiter #(.ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT), .STARVE_MAX(8)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_rdata (vid_rdata),
    .vid_ack   (vid_ack),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // RAM model: 4K image aliased by the low address bits, read data RAM_LAT cycles after ram_en.
  logic [7:0] mem [4096];
  logic [7:0] rd_pipe [RAM_LAT];

  always @(posedge clk_sys) begin
    if (ram_en && ram_we) mem[ram_addr[11:0]] <= ram_wdata;
    rd_pipe[0] <= mem[ram_addr[11:0]];
    for (int j = 1; j < RAM_LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
  end
  assign ram_rdata = rd_pipe[RAM_LAT-1];

  typedef struct {
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              exp_en;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_wdata;
    logic              exp_cpu_ack;
    logic              exp_vid_ack;
    logic              upd_cpu_rd;
    logic [7:0]        exp_cpu_rdata;
    logic              upd_vid_rd;
    logic [7:0]        exp_vid_rdata;
  } vec_t;

  vec_t vec [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ram_en"},    32'(ram_en),    32'd0);
    check({tag, " ram_we"},    32'(ram_we),    32'd0);
    check({tag, " ram_addr"},  32'(ram_addr),  32'd0);
    check({tag, " ram_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, " cpu_ack"},   32'(cpu_ack),   32'd0);
    check({tag, " vid_ack"},   32'(vid_ack),   32'd0);
    check({tag, " cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    check({tag, " vid_rdata"}, 32'(vid_rdata), 32'd0);
  endtask

  task automatic set_cpu(input int i, input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    vec[i].cpu_req = 1'b1; vec[i].cpu_we = we; vec[i].cpu_addr = a; vec[i].cpu_wdata = d;
  endtask

  task automatic set_vid(input int i, input logic [ADDR_W-1:0] a);
    vec[i].vid_req = 1'b1; vec[i].vid_addr = a;
  endtask

  task automatic set_en(input int i, input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    vec[i].exp_en = 1'b1; vec[i].exp_we = we; vec[i].exp_addr = a; vec[i].exp_wdata = d;
  endtask

  task automatic set_cack(input int i, input logic upd, input logic [7:0] d);
    vec[i].exp_cpu_ack = 1'b1; vec[i].upd_cpu_rd = upd; vec[i].exp_cpu_rdata = d;
  endtask

  task automatic set_vack(input int i, input logic [7:0] d);
    vec[i].exp_vid_ack = 1'b1; vec[i].upd_vid_rd = 1'b1; vec[i].exp_vid_rdata = d;
  endtask

  // Watches n cycles from a strobe issued in cycle 0; reports first ram_en / cpu_ack cycle.
  task automatic watch_cpu(input int n, output int en_cyc, output int ack_cyc, output logic [7:0] rd);
    en_cyc = -1; ack_cyc = -1; rd = 8'h00;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_sys);
      if (ram_en && en_cyc < 0) en_cyc = c;
      if (cpu_ack && ack_cyc < 0) begin ack_cyc = c; rd = cpu_rdata; end
      @(posedge clk_sys); #1;
      cpu_req = 1'b0;
    end
  endtask

  int         cpu_ack_cyc;
  int         cpu_en_cyc;
  int         ack_cnt;
  int         vid_q [$];
  logic [7:0] ack_rdata;
  logic [7:0] cur_cpu_rd;
  logic [7:0] cur_vid_rd;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = i[7:0] ^ 8'h3C;
    mem[12'h345] = 8'h5A;
    for (int j = 0; j < RAM_LAT; j++) rd_pipe[j] = 8'h00;

    for (int i = 0; i < NV; i++) vec[i] = '{default: '0};
    set_cpu(0, 1'b0, 24'h012345, 8'h00);  set_en(1, 1'b0, 24'h012345, 8'h00);
    set_cack(4, 1'b1, 8'h5A);
    set_cpu(6, 1'b1, 24'h00C029, 8'hA5);  set_en(7, 1'b1, 24'h00C029, 8'hA5);
    set_cack(10, 1'b0, 8'h00);
    set_cpu(12, 1'b0, 24'h00C029, 8'h00); set_vid(12, 24'h002010);
    set_en(13, 1'b0, 24'h002010, 8'h00);  set_vack(16, 8'h2C);
    set_en(17, 1'b0, 24'h00C029, 8'h00);  set_cack(20, 1'b1, 8'hA5);
    set_cpu(22, 1'b0, 24'h012345, 8'h00);
    set_cpu(23, 1'b0, 24'h00C029, 8'h00); set_en(23, 1'b0, 24'h012345, 8'h00);
    set_cpu(24, 1'b0, 24'h000000, 8'h00);
    set_cack(26, 1'b1, 8'h5A);            set_en(27, 1'b0, 24'h00C029, 8'h00);
    set_cack(30, 1'b1, 8'hA5);
    cur_cpu_rd = 8'h00;
    cur_vid_rd = 8'h00;
    for (int i = 0; i < NV; i++) begin
      if (vec[i].upd_cpu_rd) cur_cpu_rd = vec[i].exp_cpu_rdata;
      if (vec[i].upd_vid_rd) cur_vid_rd = vec[i].exp_vid_rdata;
      vec[i].exp_cpu_rdata = cur_cpu_rd;
      vec[i].exp_vid_rdata = cur_vid_rd;
    end

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    vid_req = 1'b0; vid_addr = '0;
    repeat (2) @(negedge clk_sys);
    check_all_zero("reset");
    @(posedge clk_sys); #1;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      cpu_req = vec[i].cpu_req; cpu_we = vec[i].cpu_we;
      cpu_addr = vec[i].cpu_addr; cpu_wdata = vec[i].cpu_wdata;
      vid_req = vec[i].vid_req; vid_addr = vec[i].vid_addr;
      @(negedge clk_sys);
      check($sformatf("vec%0d ram_en", i),    32'(ram_en),    32'(vec[i].exp_en));
      check($sformatf("vec%0d cpu_ack", i),   32'(cpu_ack),   32'(vec[i].exp_cpu_ack));
      check($sformatf("vec%0d vid_ack", i),   32'(vid_ack),   32'(vec[i].exp_vid_ack));
      check($sformatf("vec%0d cpu_rdata", i), 32'(cpu_rdata), 32'(vec[i].exp_cpu_rdata));
      check($sformatf("vec%0d vid_rdata", i), 32'(vid_rdata), 32'(vec[i].exp_vid_rdata));
      if (vec[i].exp_en) begin
        check($sformatf("vec%0d ram_addr", i), 32'(ram_addr), 32'(vec[i].exp_addr));
        check($sformatf("vec%0d ram_we", i),   32'(ram_we),   32'(vec[i].exp_we));
        if (vec[i].exp_we)
          check($sformatf("vec%0d ram_wdata", i), 32'(ram_wdata), 32'(vec[i].exp_wdata));
      end
      $display("vec %0d: ram_en=%0b addr=%06h cpu_ack=%0b cpu_rdata=%02h vid_ack=%0b vid_rdata=%02h",
               i, ram_en, ram_addr, cpu_ack, cpu_rdata, vid_ack, vid_rdata);
      @(posedge clk_sys); #1;
    end

    // Continuous video (re-strobe on each vid_ack) against one CPU read posted in cycle 0.
    cpu_ack_cyc = -1; cpu_en_cyc = -1; ack_rdata = 8'h00; vid_q.delete();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h012345; vid_req = 1'b1; vid_addr = 24'h002010;
`ifdef IIGS_ARB_STARVE_GUARD_EN
    for (int c = 0; c < 20; c++) begin
`else
    for (int c = 0; c < 200; c++) begin
`endif
      @(negedge clk_sys);
      if (cpu_ack && cpu_ack_cyc < 0) begin cpu_ack_cyc = c; ack_rdata = cpu_rdata; end
      if (vid_ack) vid_q.push_back(c);
      if (ram_en && ram_addr == 24'h012345 && cpu_en_cyc < 0) cpu_en_cyc = c;
      @(posedge clk_sys); #1;
      cpu_req = 1'b0;
      vid_req = vid_ack;
    end
    vid_req = 1'b0;
    $display("stream: vid_acks=%0d cpu_en_cycle=%0d cpu_ack_cycle=%0d", vid_q.size(), cpu_en_cyc, cpu_ack_cyc);
`ifdef IIGS_ARB_STARVE_GUARD_EN
    check("stream vid_ack count", 32'(vid_q.size()), 32'd3);
    if (vid_q.size() >= 3) begin
      check("stream vid_ack 1st", 32'(vid_q[0]), 32'd4);
      check("stream vid_ack 2nd", 32'(vid_q[1]), 32'd8);
      check("stream vid_ack 3rd", 32'(vid_q[2]), 32'd16);
    end
    check("stream cpu ram_en cycle", 32'(cpu_en_cyc), 32'd9);
    check("stream cpu_ack cycle",    32'(cpu_ack_cyc), 32'd12);
    check("stream cpu_rdata",        32'(ack_rdata),   32'h5A);
`else
    check("stream vid_ack count",    32'(vid_q.size()), 32'd49);
    check("stream cpu ram_en cycle", 32'(cpu_en_cyc),   32'hFFFF_FFFF);
    check("stream cpu_ack cycle",    32'(cpu_ack_cyc),  32'hFFFF_FFFF);
`endif

    // Clean restart, then reset in cycle 2 of a CPU read.
    reset = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h012345;
    @(posedge clk_sys); #1;
    cpu_req = 1'b0;
    @(posedge clk_sys); #1;
    reset = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    @(negedge clk_sys);
    check_all_zero("midreset");
    ack_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_sys); #1;
      @(negedge clk_sys);
      if (cpu_ack || ram_en) ack_cnt++;
    end
    check("midreset no activity", 32'(ack_cnt), 32'd0);
    $display("midreset: activity cycles after reset=%0d", ack_cnt);

    @(posedge clk_sys); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h012345;
    watch_cpu(7, cpu_en_cyc, cpu_ack_cyc, ack_rdata);
    $display("fresh read: ram_en cycle=%0d cpu_ack cycle=%0d rdata=%02h", cpu_en_cyc, cpu_ack_cyc, ack_rdata);
    check("fresh ram_en cycle",  32'(cpu_en_cyc),  32'd1);
    check("fresh cpu_ack cycle", 32'(cpu_ack_cyc), 32'd4);
    check("fresh cpu_rdata",     32'(ack_rdata),   32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iigs_ram_arbiter.md
# iigs_ram_arbiter

Two-port arbiter that shares the single IIgs main-RAM port between the 65816 CPU bus and the video scanner. It sits between the CPU/video fetch logic and the RAM under `top`, in the `clk_sys` domain. Each requester posts single-cycle strobes; the arbiter latches them, sequences one RAM access at a time with a fixed read latency, and returns a one-cycle ack. Video has priority, and an optional starvation guard bounds CPU wait.

## Interface
- `ADDR_W`, 24: RAM address width (bank:address).
- `RAM_LAT`, 2: RAM read latency in cycles, ≥1.
- `STARVE_MAX`, 8: CPU wait threshold in cycles for the starvation guard; 1..15.

Ports:
- `clk_sys`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  one-cycle CPU access strobe.
- `cpu_we`  in  1  write when 1; sampled with `cpu_req`.
- `cpu_addr`  in  ADDR_W  CPU address; sampled with `cpu_req`.
- `cpu_wdata`  in  8  write data; sampled with `cpu_req`.
- `cpu_rdata`  out  8  read data; valid while `cpu_ack`=1, held afterwards.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `vid_req`  in  1  one-cycle video read strobe.
- `vid_addr`  in  ADDR_W  video address; sampled with `vid_req`.
- `vid_rdata`  out  8  read data; valid while `vid_ack`=1, held afterwards.
- `vid_ack`  out  1  one-cycle completion pulse.
- `ram_en`  out  1  RAM access strobe, one cycle per access.
- `ram_we`  out  1  RAM write enable, qualified by `ram_en`.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  8  RAM write data.
- `ram_rdata`  in  8  RAM read data, valid `RAM_LAT` cycles after `ram_en`.

## Operation
- A strobe latches its address, data, and we into a per-requester pending slot. A strobe while that requester's slot is already pending is dropped (protocol violation). A strobe arriving while the requester's previous access is in flight is accepted, because the slot clears at grant.
- States:
  - IDLE: arbitrates over pending slots, including a strobe arriving this same cycle.
    - Video wins if pending.
    - Otherwise CPU wins if pending.
    - The winner's slot clears and the state moves to ISSUE.
  - ISSUE: one cycle with `ram_en`=1 and the winner's address, we, and wdata. Then WAIT.
  - WAIT: counts `RAM_LAT` cycles and captures `ram_rdata` on the last edge. Then ACK.
  - ACK: pulses the winner's ack for one cycle with its rdata updated, and arbitrates exactly as IDLE does in the same cycle. It then goes to ISSUE if something is granted, else IDLE.
- CPU writes follow identical timing. `cpu_rdata` is not updated on a write ack.
- Video is read-only. `ram_we`=0 for every video access.
- `ram_addr`, `ram_we`, and `ram_wdata` are don't-care when `ram_en`=0, but hold their last value.

## Timing
- Reset values:
  - All outputs are 0.
  - Pending slots are clear and the state is IDLE.
  - The wait counter is 0.
- Reset mid-access: the in-flight access is abandoned and no ack is issued. A write whose ISSUE cycle already occurred may have landed in RAM.
- A grant at cycle k gives `ram_en` at k+1 and the ack at k+`RAM_LAT`+2. The default access period is 4 cycles, back-to-back.
- Simultaneous pending at arbitration: video first. The CPU is granted at the video ack cycle unless video has re-posted by then.
- Ack pulses are exactly one cycle. `cpu_ack` and `vid_ack` are never high together.

## Configuration
- `IIGS_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit saturating counter increments at the end of every cycle in which the CPU slot is pending and not granted. It clears on CPU grant.
  - At arbitration, if the counter ≥ `STARVE_MAX`, the CPU wins over video.
- Undefined: strict video priority. A video stream that re-posts every ack can starve the CPU indefinitely.

## Test plan
- CPU read, RAM model returns 0x5A at 0x012345: `cpu_req` at cycle 0 → `ram_en`=1 with `ram_addr`=0x012345 at cycle 1; `cpu_ack`=1 with `cpu_rdata`=0x5A at cycle 4.
- CPU write 0xA5 to 0x00C029 at cycle 0 → `ram_en`=1 with `ram_we`=1 and `ram_wdata`=0xA5 at cycle 1; `cpu_ack` at cycle 4; `cpu_rdata` unchanged.
- `cpu_req` and `vid_req` both at cycle 0 → `vid_ack` at cycle 4, `cpu_ack` at cycle 8.
- Continuous video (re-strobe on every `vid_ack`) plus `cpu_req` at cycle 0, with guard enabled → video acks at 4 and 8, CPU granted at cycle 8, `cpu_ack` at 12.
- Same stimulus with guard disabled → no `cpu_ack` within 200 cycles.
- Assert `reset` at cycle 2 of a CPU read → no `cpu_ack`; all outputs 0 in the following cycle. A fresh `cpu_req` after release completes in 4 cycles.
